// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of {PC, NEXTPC, INS} entries
// with valid/ready handshakes on both sides and a synchronous flush for taken branches.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [31:0]   IN_PC,
    input  logic [31:0]   IN_NEXTPC,
    input  logic [31:0]   IN_INS,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [31:0]   OUT_PC,
    output logic [31:0]   OUT_NEXTPC,
    output logic [31:0]   OUT_INS,
    input  logic          FLUSH,
    output logic [CW-1:0] COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [95:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [95:0]   head;

    assign IN_READY  = (count_q != FULL);
    assign OUT_VALID = (count_q != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign COUNT     = count_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (FLUSH) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; stale contents are hidden by the OUT_VALID mask.
    always_ff @(posedge CLK) begin
        if (push && !FLUSH) begin
            mem_q[wp_q] <= {IN_PC, IN_NEXTPC, IN_INS};
        end
    end

    assign head       = OUT_VALID ? mem_q[rp_q] : 96'h0;
    assign OUT_PC     = head[95:64];
    assign OUT_NEXTPC = head[63:32];
    assign OUT_INS    = head[31:0];

endmodule
